// File: rtl/combination_lock_seq.sv
// combination_lock_seq
// Multi-digit combination lock controller. It collects keyed digits into an
// entry buffer and compares them against a stored code. The code can be
// changed on the device. Failed attempts are counted, and reaching
// MAX_TRIES raises a sticky alarm. The open state relocks by itself after
// OPEN_CYCLES clock cycles.
//
// Optional feature macro: COMBO_ALARM_CLEAR_EN
//   When defined, this adds the alarm_clear input, which releases ALARM
//   back to IDLE. The stored code is kept.
//   When undefined, ALARM is left only through resetn.

module combination_lock_seq #(
    parameter int DIGIT_W     = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 16,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] RESET_CODE = '0
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               digit_valid,
`ifdef COMBO_ALARM_CLEAR_EN
    input  logic                               alarm_clear,
`endif
    input  logic                               enter,
    input  logic                               change,
    output logic                               open,
    output logic                               new_code,
    output logic                               alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W  = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(OPEN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_NEW   = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    // Shift one digit into the low end of the entry buffer. The oldest
    // digit falls off the top, so the first keyed digit ends up in the
    // most significant position once the buffer is full.
    function automatic logic [CODE_W-1:0] shift_in(
        input logic [CODE_W-1:0]  b,
        input logic [DIGIT_W-1:0] d
    );
        logic [CODE_W+DIGIT_W-1:0] wide;
        wide = {b, d};
        return wide[CODE_W-1:0];
    endfunction

    // Add one failed attempt, saturating at MAX_TRIES.
    function automatic logic [FAIL_W-1:0] fail_bump(input logic [FAIL_W-1:0] f);
        logic [FAIL_W-1:0] r;
        if (f >= FAIL_MAX) begin
            r = FAIL_MAX;
        end else begin
            r = f + FAIL_W'(1);
        end
        return r;
    endfunction

    state_e              state_q,    state_d;
    logic [CODE_W-1:0]   code_q,     code_d;
    logic [CODE_W-1:0]   entry_q,    entry_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [TMR_W-1:0]    timer_q,    timer_d;
    logic [FAIL_W-1:0]   fail_q,     fail_d;
    logic                open_q,     open_d;
    logic                new_code_q, new_code_d;
    logic                alarm_q,    alarm_d;

    logic                alarm_clear_s;
    logic                match_s;
    logic                digit_take_s;
    logic                full_s;
    logic [FAIL_W-1:0]   fail_inc_s;

`ifdef COMBO_ALARM_CLEAR_EN
    assign alarm_clear_s = alarm_clear;
`else
    assign alarm_clear_s = 1'b0;
`endif

    // Entry-buffer status and the failure count a rejected submit would produce.
    always_comb begin
        full_s       = (cnt_q == CNT_FULL);
        match_s      = full_s && (entry_q == code_q);
        digit_take_s = digit_valid && (cnt_q < CNT_FULL);
        fail_inc_s   = fail_bump(fail_q);
    end

    // Next-state, datapath updates and Moore output decode of the next state.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (enter || change) begin
                    // Digits in the same cycle are dropped. The comparison uses
                    // the buffer contents from before this edge.
                    entry_d = '0;
                    cnt_d   = '0;
                    if (match_s) begin
                        fail_d = '0;
                        if (enter) begin
                            state_d = ST_OPEN;
                            timer_d = TMR_LOAD;
                        end else begin
                            state_d = ST_NEW;
                        end
                    end else begin
                        fail_d = fail_inc_s;
                        if (fail_inc_s == FAIL_MAX) begin
                            state_d = ST_ALARM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (digit_take_s) begin
                    entry_d = shift_in(entry_q, digit);
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_OPEN: begin
                // Digits are ignored while open. The buffer is already empty here.
                if (enter || (timer_q == '0)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_NEW: begin
                if (enter) begin
                    // A short entry aborts the change. It does not count as a failure.
                    if (full_s) begin
                        code_d = entry_q;
                    end else begin
                        code_d = code_q;
                    end
                    state_d = ST_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (change) begin
                    state_d = ST_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (digit_take_s) begin
                    entry_d = shift_in(entry_q, digit);
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_NEW;
                end
            end

            ST_ALARM: begin
                if (alarm_clear_s) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ALARM;
                end
            end

            default: begin
                state_d = ST_IDLE;
                entry_d = '0;
                cnt_d   = '0;
                timer_d = '0;
                fail_d  = '0;
            end
        endcase

        open_d     = (state_d == ST_OPEN);
        new_code_d = (state_d == ST_NEW);
        alarm_d    = (state_d == ST_ALARM);
    end

    // State, datapath and output registers. Reset returns to IDLE with the reset code.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            code_q     <= RESET_CODE;
            entry_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            fail_q     <= '0;
            open_q     <= 1'b0;
            new_code_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            open_q     <= open_d;
            new_code_q <= new_code_d;
            alarm_q    <= alarm_d;
        end
    end

    assign open       = open_q;
    assign new_code   = new_code_q;
    assign alarm      = alarm_q;
    assign fail_count = fail_q;

endmodule
